// File: rtl/board_entry_pkg.sv
// Shared definitions for the puzzle board entry block.
package board_entry_pkg;

    localparam int NUM_CELLS = 9;
    localparam int TILE_W    = 4;
    localparam int BOARD_W   = NUM_CELLS * TILE_W;
    localparam int NUM_BTN   = 5;

    localparam int BTN_INC    = 0;
    localparam int BTN_DEC    = 1;
    localparam int BTN_NEXT   = 2;
    localparam int BTN_PREV   = 3;
    localparam int BTN_COMMIT = 4;

    localparam logic [TILE_W-1:0]  LAST_IDX     = 4'd8;
    localparam logic [BOARD_W-1:0] SOLVED_BOARD = 36'h087654321;

    typedef enum logic [1:0] {
        ST_EDIT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_SEND  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    // Tile and cursor values wrap within 0..8.
    function automatic logic [TILE_W-1:0] wrap_inc(input logic [TILE_W-1:0] v);
        return (v >= LAST_IDX) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [TILE_W-1:0] wrap_dec(input logic [TILE_W-1:0] v);
        return (v == 4'd0) ? LAST_IDX : v - 4'd1;
    endfunction

endpackage

// File: rtl/board_entry_btn_debounce.sv
// One pushbutton: 2-flop synchronizer, stable-time debouncer, rising-level press pulse.
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int                CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             level_dly_q, level_dly_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only advances while the synchronized input disagrees with the
    // accepted level; a single agreeing cycle restarts the stability window.
    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        level_d     = level_q;
        cnt_d       = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        level_dly_d = level_q;
        press_d     = level_q & ~level_dly_q;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/board_entry.sv
// Pushbutton puzzle board editor with duplicate check and valid/ready hand-off.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_EDIT  | buttons edit the cell under the cursor or move the cursor
//   ST_CHECK | scan one cell per cycle for a repeated tile value
//   ST_SEND  | board offered downstream, held until accepted
//   ST_ERR   | duplicate found; any press returns to edit without editing
module board_entry
    import board_entry_pkg::*;
#(
    parameter int DB_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn,
    output logic [BOARD_W-1:0] board,
    output logic               board_valid,
    input  logic               board_ready,
    output logic [TILE_W-1:0]  cursor,
    output logic               err
);

    logic [NUM_BTN-1:0] press;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (btn[i]),
            .press   (press[i])
        );
    end

    state_t               state_q, state_d;
    logic [BOARD_W-1:0]   board_q, board_d;
    logic [TILE_W-1:0]    cursor_q, cursor_d;
    logic [TILE_W-1:0]    scan_q, scan_d;
    logic [NUM_CELLS-1:0] seen_q, seen_d;
    logic [TILE_W-1:0]    cell_cur;
    logic [TILE_W-1:0]    cell_scan;

    // Next-state logic; the if-chain order gives commit > prev > next > dec > inc.
    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        cursor_d  = cursor_q;
        scan_d    = scan_q;
        seen_d    = seen_q;
        cell_cur  = board_q[{cursor_q, 2'b00} +: TILE_W];
        cell_scan = board_q[{scan_q, 2'b00} +: TILE_W];
        case (state_q)
            ST_EDIT: begin
                if (press[BTN_COMMIT]) begin
                    state_d = ST_CHECK;
                    scan_d  = '0;
                    seen_d  = '0;
                end else if (press[BTN_PREV]) begin
                    cursor_d = wrap_dec(cursor_q);
                end else if (press[BTN_NEXT]) begin
                    cursor_d = wrap_inc(cursor_q);
                end else if (press[BTN_DEC]) begin
                    board_d[{cursor_q, 2'b00} +: TILE_W] = wrap_dec(cell_cur);
                end else if (press[BTN_INC]) begin
                    board_d[{cursor_q, 2'b00} +: TILE_W] = wrap_inc(cell_cur);
                end
            end
            ST_CHECK: begin
                if (seen_q[cell_scan]) begin
                    state_d = ST_ERR;
                end else begin
                    seen_d[cell_scan] = 1'b1;
                    if (scan_q == LAST_IDX) begin
                        state_d = ST_SEND;
                    end else begin
                        scan_d = scan_q + 4'd1;
                    end
                end
            end
            ST_SEND: begin
                if (board_ready) begin
                    state_d = ST_EDIT;
                end
            end
            ST_ERR: begin
                if (|press) begin
                    state_d = ST_EDIT;
                end
            end
            default: state_d = ST_EDIT;
        endcase
    end

    // State and board storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EDIT;
            board_q  <= SOLVED_BOARD;
            cursor_q <= '0;
            scan_q   <= '0;
            seen_q   <= '0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            cursor_q <= cursor_d;
            scan_q   <= scan_d;
            seen_q   <= seen_d;
        end
    end

    assign board       = board_q;
    assign cursor      = cursor_q;
    assign board_valid = (state_q == ST_SEND);
    assign err         = (state_q == ST_ERR);

endmodule

// File: tb/tb_board_entry.sv
// Self-checking bench for board_entry with a behavioural board/cursor model.
module tb_board_entry;

    localparam int DB = 4;
    localparam logic [35:0] SOLVED = 36'h087654321;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  btn;
    logic [35:0] board;
    logic        board_valid;
    logic        board_ready;
    logic [3:0]  cursor;
    logic        err;

    int          n_checks = 0;
    int          n_errors = 0;
    int          xfer_cnt = 0;
    logic [35:0] xfer_board = '0;

    int m_cell[9];
    int m_cursor;
    bit m_err;
    bit m_send;
    int m_xfers = 0;

    board_entry #(.DB_CYCLES(DB)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .board       (board),
        .board_valid (board_valid),
        .board_ready (board_ready),
        .cursor      (cursor),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Record every accepted transfer.
    always @(posedge clk) begin
        if (!rst && board_valid && board_ready) begin
            xfer_cnt   = xfer_cnt + 1;
            xfer_board = board;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] m_pack();
        logic [35:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b[i*4 +: 4] = 4'(m_cell[i]);
        return b;
    endfunction

    function automatic bit m_has_dup();
        int cnt[9];
        for (int i = 0; i < 9; i++) cnt[i] = 0;
        for (int i = 0; i < 9; i++) begin
            cnt[m_cell[i]]++;
            if (cnt[m_cell[i]] > 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_cell   = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
        m_cursor = 0;
        m_err    = 1'b0;
        m_send   = 1'b0;
    endtask

    task automatic model_press(input logic [4:0] mask);
        if (mask == 5'd0) return;
        if (m_err) begin
            m_err = 1'b0;
            return;
        end
        if (mask[4]) begin
            if (m_has_dup()) m_err = 1'b1;
            else m_send = 1'b1;
        end else if (mask[3]) m_cursor = (m_cursor + 8) % 9;
        else if (mask[2]) m_cursor = (m_cursor + 1) % 9;
        else if (mask[1]) m_cell[m_cursor] = (m_cell[m_cursor] + 8) % 9;
        else m_cell[m_cursor] = (m_cell[m_cursor] + 1) % 9;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        btn = '0;
        board_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic press_btn(input logic [4:0] mask);
        @(negedge clk);
        btn = mask;
        repeat (DB + 6) @(negedge clk);
        btn = '0;
        repeat (DB + 6) @(negedge clk);
        model_press(mask);
    endtask

    task automatic check_all(input string tag);
        check_val({tag, " board"},  64'(board),       64'(m_pack()));
        check_val({tag, " cursor"}, 64'(cursor),      64'(m_cursor));
        check_val({tag, " err"},    64'(err),         64'(m_err));
        check_val({tag, " valid"},  64'(board_valid), 64'(m_send));
        check_val({tag, " xfers"},  64'(xfer_cnt),    64'(m_xfers));
    endtask

    task automatic handshake(input string tag);
        if (!m_send) return;
        repeat ($urandom_range(0, 4)) begin
            @(negedge clk);
            check_val({tag, " hold valid"}, 64'(board_valid), 64'd1);
            check_val({tag, " hold board"}, 64'(board), 64'(m_pack()));
        end
        @(negedge clk);
        board_ready = 1'b1;
        @(negedge clk);
        board_ready = 1'b0;
        m_send = 1'b0;
        m_xfers++;
        check_val({tag, " valid after xfer"}, 64'(board_valid), 64'd0);
        check_val({tag, " xfer board"}, 64'(xfer_board), 64'(m_pack()));
        check_val({tag, " xfer count"}, 64'(xfer_cnt), 64'(m_xfers));
    endtask

    initial begin
        logic [4:0] mask;
        int         r;

        rst = 1'b1;
        btn = '0;
        board_ready = 1'b0;
        model_reset();

        // Reset state
        do_reset();
        check_all("reset");

        // Held increment: exact latency and single action
        @(negedge clk);
        btn = 5'b00001;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (e == 6) check_val("inc before edge7", 64'(board), 64'(SOLVED));
            if (e == 7) check_val("inc at edge7 cell0", 64'(board[3:0]), 64'd2);
        end
        @(negedge clk);
        btn = '0;
        repeat (DB + 6) @(negedge clk);
        model_press(5'b00001);
        check_all("held inc");

        // Glitch rejection and cursor wrap
        do_reset();
        @(negedge clk);
        btn = 5'b00100;
        repeat (3) @(negedge clk);
        btn = '0;
        repeat (12) @(negedge clk);
        check_all("glitch");
        press_btn(5'b01000);
        check_all("prev wrap");
        press_btn(5'b00100);
        check_all("next wrap");

        // Commit of the solved board: check duration, hold, single transfer
        do_reset();
        @(negedge clk);
        btn = 5'b10000;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (e == 15) check_val("valid before scan done", 64'(board_valid), 64'd0);
            if (e == 16) check_val("valid after 9 scan cycles", 64'(board_valid), 64'd1);
        end
        @(negedge clk);
        btn = '0;
        model_press(5'b10000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("send hold valid", 64'(board_valid), 64'd1);
            check_val("send hold board", 64'(board), 64'(SOLVED));
        end
        handshake("solved");
        repeat (DB + 6) @(negedge clk);
        check_all("after send");

        // Duplicate rejection and error recovery
        do_reset();
        press_btn(5'b00001);
        check_all("dup setup");
        press_btn(5'b10000);
        check_all("dup commit");
        press_btn(5'b00010);
        check_all("err clear");
        press_btn(5'b00010);
        check_all("dec after err");

        // Simultaneous inc+commit, then reset during SEND
        do_reset();
        press_btn(5'b10001);
        check_all("inc+commit");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst in send valid", 64'(board_valid), 64'd0);
        check_val("rst in send board", 64'(board), 64'(SOLVED));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (DB + 6) @(negedge clk);
        check_all("after send rst");

        // Reset during CHECK
        @(negedge clk);
        btn = 5'b10000;
        repeat (10) @(negedge clk);
        btn = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (20) @(negedge clk);
        check_all("rst in check");

        // Randomized presses against the model
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 99);
            if (r < 30)      mask = 5'b00001;
            else if (r < 45) mask = 5'b00010;
            else if (r < 60) mask = 5'b00100;
            else if (r < 75) mask = 5'b01000;
            else if (r < 85) mask = 5'b10000;
            else             mask = 5'($urandom_range(1, 31));
            board_ready = mask[4] ? 1'b0 : 1'($urandom_range(0, 1));
            press_btn(mask);
            board_ready = 1'b0;
            check_all($sformatf("rand%0d m%0h", n, mask));
            handshake($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/board_entry.md
BOARD_ENTRY -- requirements
Module: board_entry

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 16, meaning consecutive stable cycles required to accept a button level change (min 2).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 btn  input  5  raw asynchronous pushbuttons; [0]=inc, [1]=dec, [2]=next, [3]=prev, [4]=commit.
REQ-005 board  output  36  puzzle board, cell k in bits [4k+3:4k], k=0..8, row-major; value 0 = blank.
REQ-006 board_valid  output  1  board offered to the processor side.
REQ-007 board_ready  input  1  consumer accepts the board; transfer occurs on a cycle with board_valid & board_ready.
REQ-008 cursor  output  4  index (0..8) of the cell being edited.
REQ-009 err  output  1  high while the last committed board was rejected.

Function
REQ-010 Each btn bit SHALL pass through a 2-flop synchronizer, then a debouncer: a counter runs while the synchronized input differs from the debounced level, clears when they match, and the level toggles on the edge the counter reaches DB_CYCLES-1 with inputs still differing.
REQ-011 A press SHALL be a one-cycle pulse on the cycle after the debounced level rises; release generates nothing; holding generates no repeats.
REQ-012 Latency: raw btn high and held from edge 0 SHALL update board/cursor on edge 3+DB_CYCLES.
REQ-013 Simultaneous presses SHALL resolve by priority commit > prev > next > dec > inc; only the winner acts that cycle, others are discarded.
REQ-014 FSM states: EDIT, CHECK, SEND, ERR; reset state EDIT.
REQ-015 EDIT: inc sets cell[cursor] = (v+1) mod 9 (8 -> 0); dec sets (v+8) mod 9 (0 -> 8); next increments cursor, 8 -> 0; prev decrements cursor, 0 -> 8; commit -> CHECK with scan index 0 and 9-bit seen mask cleared.
REQ-016 CHECK: one cell per cycle, 9 cycles; if seen[cell value] already set -> ERR immediately; otherwise set the bit; after cell 8 with no duplicate -> SEND.
REQ-017 SEND: board_valid = 1 and board held constant; on the handshake edge -> EDIT, board_valid low the next cycle; board_ready while not in SEND SHALL have no effect.
REQ-018 ERR: err = 1; board and cursor kept; the next press of any button -> EDIT with err = 0, and that press performs no edit.
REQ-019 Presses arriving in CHECK or SEND SHALL be discarded; debouncers keep running in all states.
REQ-020 board_valid SHALL be 1 only in SEND; err SHALL be 1 only in ERR.
REQ-021 Tile values SHALL always be in 0..8; a duplicate-free board is therefore a valid permutation.

Reset
REQ-022 On rst: board = cells 0..8 = 1,2,3,4,5,6,7,8,0 (0x087654321); cursor = 0; board_valid = 0; err = 0; state EDIT; synchronizers, debounced levels and counters = 0.
REQ-023 Reset asserted in any state, including mid-SEND or mid-CHECK, SHALL take effect on that edge with no pending transfer retained.

Structure
REQ-024 Shared package SHALL hold: state encoding, button index constants, solved-board constant, cell count 9, tile width 4.
REQ-025 Sub-module btn_debounce (synchronizer + debouncer + press pulse, parameter DB_CYCLES) SHALL be instantiated 5 times; the FSM and board storage stay in board_entry.

Verification (DB_CYCLES = 4)
REQ-026 Reset, hold btn[0] 20 cycles -> cell0 1 -> 2 exactly at edge 7, single increment only.
REQ-027 Glitch btn[2] high for 3 cycles -> cursor unchanged; btn[3] pulse from reset -> cursor 8; then btn[2] -> cursor 0.
REQ-028 From reset, btn[4] -> 9 CHECK cycles, board_valid rises; board_ready low 5 cycles holds board 0x087654321 stable; ready high -> one transfer, valid low next cycle.
REQ-029 Cell0 inc to 2 (duplicate of cell1), commit -> err = 1 and no valid; then btn[1] -> err = 0, board unchanged; next btn[1] -> cell0 = 1.
REQ-030 btn[0] and btn[4] debounced on the same edge -> commit only, board unchanged; rst asserted during SEND -> valid 0 and reset board next cycle.
